// File: rtl/hit_encoder8to3_if.sv
// Valid/ready handshake bundle around the way-hit encoder.
// master = side that supplies hit vectors and consumes results (tag-compare / data-array control).
// slave  = the encoder itself.
interface hit_encoder8to3_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_hit;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_way;
  logic       out_hit;
  logic       out_multi;

  modport master (
    output in_valid, in_hit, out_ready,
    input  in_ready, out_valid, out_way, out_hit, out_multi
  );

  modport slave (
    input  in_valid, in_hit, out_ready,
    output in_ready, out_valid, out_way, out_hit, out_multi
  );
endinterface

// File: rtl/hit_encoder8to3.sv
// Registered 8-to-3 way-hit encoder with miss / multi-hit flags and a
// saturating multi-hit error counter. Single output stage, valid/ready on both sides.
module hit_encoder8to3 #(
  parameter bit          PRIORITY_LSB = 1'b1,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  hit_encoder8to3_if.slave     bus,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic       accept;
  logic [2:0] way_enc;
  logic       hit_enc;
  logic       multi_enc;

  logic                 out_valid_q, out_valid_d;
  logic [2:0]           out_way_q,   out_way_d;
  logic                 out_hit_q,   out_hit_d;
  logic                 out_multi_q, out_multi_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,   err_cnt_d;

  // The output register is free when empty or being drained this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Priority encode the hit vector; the last match written in the scan wins.
  always_comb begin
    way_enc = 3'd0;
    if (PRIORITY_LSB) begin
      for (int i = 7; i >= 0; i--) begin
        if (bus.in_hit[i]) way_enc = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.in_hit[i]) way_enc = 3'(i);
      end
    end
    hit_enc   = |bus.in_hit;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_enc = (bus.in_hit & (bus.in_hit - 8'd1)) != 8'd0;
  end

  // Next-state for the output stage and the error counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_way_d   = out_way_q;
    out_hit_d   = out_hit_q;
    out_multi_d = out_multi_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_way_d   = way_enc;
      out_hit_d   = hit_enc;
      out_multi_d = multi_enc;
    end else if (bus.out_ready) begin
      // Result drained with nothing new behind it; payload keeps its last value.
      out_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && multi_enc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Output stage and counter registers; reset drops any held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_way_q   <= 3'd0;
      out_hit_q   <= 1'b0;
      out_multi_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_way_q   <= out_way_d;
      out_hit_q   <= out_hit_d;
      out_multi_q <= out_multi_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_way   = out_way_q;
  assign bus.out_hit   = out_hit_q;
  assign bus.out_multi = out_multi_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_hit_encoder8to3.sv
// Directed bench: dut_a uses defaults (LSB priority, 8-bit counter),
// dut_b uses MSB priority and a 2-bit counter. Both see identical stimulus.
module tb_hit_encoder8to3;

  logic clk;
  logic reset;
  logic err_clr;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  int n_checks;
  int n_pass;

  hit_encoder8to3_if if_a ();
  hit_encoder8to3_if if_b ();

  hit_encoder8to3 #(.PRIORITY_LSB(1'b1), .ERR_CNT_W(8)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .bus     (if_a.slave),
    .err_clr (err_clr),
    .err_cnt (err_cnt_a)
  );

  hit_encoder8to3 #(.PRIORITY_LSB(1'b0), .ERR_CNT_W(2)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .bus     (if_b.slave),
    .err_clr (err_clr),
    .err_cnt (err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] h, input logic r);
    if_a.in_valid = v; if_a.in_hit = h; if_a.out_ready = r;
    if_b.in_valid = v; if_b.in_hit = h; if_b.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output picture of both instances in one call.
  task automatic check_out(input string tag, input logic v, input logic [2:0] wa, input logic [2:0] wb,
                           input logic h, input logic m);
    check({tag, " valid_a"}, 32'(if_a.out_valid), 32'(v));
    check({tag, " way_a"},   32'(if_a.out_way),   32'(wa));
    check({tag, " hit_a"},   32'(if_a.out_hit),   32'(h));
    check({tag, " multi_a"}, 32'(if_a.out_multi), 32'(m));
    check({tag, " valid_b"}, 32'(if_b.out_valid), 32'(v));
    check({tag, " way_b"},   32'(if_b.out_way),   32'(wb));
    check({tag, " hit_b"},   32'(if_b.out_hit),   32'(h));
    check({tag, " multi_b"}, 32'(if_b.out_multi), 32'(m));
  endtask

  task automatic check_cnt(input string tag, input int ea, input int eb);
    check({tag, " err_a"}, 32'(err_cnt_a), 32'(ea));
    check({tag, " err_b"}, 32'(err_cnt_b), 32'(eb));
  endtask

  task automatic check_rdy(input string tag, input logic e);
    check({tag, " in_ready_a"}, 32'(if_a.in_ready), 32'(e));
    check({tag, " in_ready_b"}, 32'(if_b.in_ready), 32'(e));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    err_clr  = 1'b0;
    drive(1'b0, 8'h00, 1'b1);

    // Reset state
    step();
    check_out("reset", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    check_cnt("reset", 0, 0);
    step();
    reset = 1'b0;
    #1;
    check_rdy("post_reset", 1'b1);

    // 1: single one-hot
    drive(1'b1, 8'b0001_0000, 1'b1);
    step();
    check_out("onehot4", 1'b1, 3'd4, 3'd4, 1'b1, 1'b0);

    // 2: back-to-back sweep, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(1 << i), 1'b1);
      step();
      check_out($sformatf("sweep%0d", i), 1'b1, 3'(i), 3'(i), 1'b1, 1'b0);
      check_rdy($sformatf("sweep%0d", i), 1'b1);
    end
    check_cnt("sweep", 0, 0);

    // 3: miss, then multi-hit with opposite priorities
    drive(1'b1, 8'h00, 1'b1);
    step();
    check_out("miss", 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 8'b1000_0100, 1'b1);
    step();
    check_out("multi84", 1'b1, 3'd2, 3'd7, 1'b1, 1'b1);
    check_cnt("multi84", 1, 1);

    // Drain without accept: valid drops, payload holds
    drive(1'b0, 8'hFF, 1'b1);
    step();
    check_out("drain", 1'b0, 3'd2, 3'd7, 1'b1, 1'b1);
    check_cnt("drain", 1, 1);

    // 4: backpressure
    drive(1'b1, 8'h02, 1'b1);
    step();
    check_out("bp_load", 1'b1, 3'd1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 8'h40, 1'b0);
    #1;
    check_rdy("bp_stall", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 3'd1, 3'd1, 1'b1, 1'b0);
      check_rdy($sformatf("bp_hold%0d", i), 1'b0);
    end
    drive(1'b1, 8'h40, 1'b1);
    #1;
    check_rdy("bp_release", 1'b1);
    step();
    check_out("bp_after", 1'b1, 3'd6, 3'd6, 1'b1, 1'b0);

    // Stalled multi-hit vectors must not count
    drive(1'b1, 8'h03, 1'b0);
    step();
    step();
    check_out("stall_multi", 1'b1, 3'd6, 3'd6, 1'b1, 1'b0);
    check_cnt("stall_multi", 1, 1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check_cnt("stall_drop", 1, 1);

    // 5: saturation (dut_b 2-bit counter) and clear priority
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 8'hFF, 1'b1);
      step();
      check_cnt($sformatf("sat%0d", k), 1 + k, (1 + k > 3) ? 3 : 1 + k);
    end
    check_out("satFF", 1'b1, 3'd0, 3'd7, 1'b1, 1'b1);
    drive(1'b1, 8'h11, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_cnt("clr_vs_inc", 0, 0);
    check_out("clr_vs_inc", 1'b1, 3'd0, 3'd4, 1'b1, 1'b1);

    // 6: reset during a stall with a valid result held
    drive(1'b1, 8'h21, 1'b1);
    step();
    check_cnt("pre_rst", 1, 1);
    drive(1'b1, 8'h08, 1'b0);
    step();
    check_out("pre_rst", 1'b1, 3'd0, 3'd5, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    check_cnt("async_rst", 0, 0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    reset = 1'b0;
    step();
    check_out("after_rst", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    check_rdy("after_rst", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
